// File: rtl/usb_tx_packet_gen.sv
// USB transmit packet generator: sequences SYNC, PID, payload and CRC16 bytes
// to a serializer over a valid/ack handshake, then requests end-of-packet.
module usb_tx_packet_gen #(
   parameter int MAX_BYTES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [2:0] tx_packet,
   input  logic [6:0] tx_data_count,
   input  logic [7:0] buf_data,
   output logic       buf_get,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ack,
   output logic       eop_req,
   input  logic       eop_done,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int         CW        = (MAX_BYTES < 1) ? 1 : $clog2(MAX_BYTES + 1);
   localparam logic [6:0] MAX_CNT   = 7'(MAX_BYTES);
   localparam logic [2:0] PKT_DATA0 = 3'b001;
   localparam logic [2:0] PKT_DATA1 = 3'b010;
   localparam logic [2:0] PKT_ACK   = 3'b011;
   localparam logic [2:0] PKT_NAK   = 3'b100;
   localparam logic [2:0] PKT_STALL = 3'b101;

   typedef enum logic [2:0] {
      IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [2:0]      r_pkt;
   logic [CW-1:0]   r_cnt;
   logic [15:0]     r_crc;
   logic [15:0]     w_crc_nxt;
   logic [7:0]      r_byte;
   logic            r_valid;
   logic            r_err;
   logic [7:0]      w_pid;
   logic            w_in_data;
   logic            w_in_legal;
   logic            w_launch;
   logic            w_reject;
   logic            w_ack;
   logic            w_pkt_data;
   logic            w_cnt_zero;
   logic            w_cnt_last;
   logic            w_get;

   assign w_in_data  = (tx_packet == PKT_DATA0) || (tx_packet == PKT_DATA1);
   assign w_in_legal = (tx_packet >= PKT_DATA0) && (tx_packet <= PKT_STALL) &&
                       !(w_in_data && (tx_data_count > MAX_CNT));
   assign w_launch   = (r_state == IDLE) && tx_start && w_in_legal;
   assign w_reject   = (r_state == IDLE) && tx_start && !w_in_legal;
   // An ack only counts while a byte is actually on offer.
   assign w_ack      = byte_ack && r_valid;
   assign w_pkt_data = (r_pkt == PKT_DATA0) || (r_pkt == PKT_DATA1);
   assign w_cnt_zero = (r_cnt == '0);
   assign w_cnt_last = (r_cnt == CW'(1));

   always_comb begin
      w_pid = 8'h00;
      case (r_pkt)
         PKT_DATA0: w_pid = 8'hC3;
         PKT_DATA1: w_pid = 8'h4B;
         PKT_ACK:   w_pid = 8'hD2;
         PKT_NAK:   w_pid = 8'h5A;
         PKT_STALL: w_pid = 8'h1E;
         default:   w_pid = 8'h00;
      endcase
   end

   // Reflected CRC16 (0x8005 -> 0xA001), one whole byte folded per load.
   always_comb begin
      w_crc_nxt = r_crc;
      for (int i = 0; i < 8; i++) begin
         w_crc_nxt = {1'b0, w_crc_nxt[15:1]} ^
                     ((w_crc_nxt[0] ^ buf_data[i]) ? 16'hA001 : 16'h0000);
      end
   end

   always_comb begin
      w_get = 1'b0;
      if (!rst && w_ack) begin
         if (r_state == PID)       w_get = w_pkt_data && !w_cnt_zero;
         else if (r_state == DATA) w_get = !w_cnt_last;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:   if (w_launch) w_state_nxt = SYNC;
         SYNC:   if (w_ack) w_state_nxt = PID;
         PID: begin
            if (w_ack) begin
               if (!w_pkt_data)     w_state_nxt = EOP;
               else if (w_cnt_zero) w_state_nxt = CRC_LO;
               else                 w_state_nxt = DATA;
            end
         end
         DATA:   if (w_ack && w_cnt_last) w_state_nxt = CRC_LO;
         CRC_LO: if (w_ack) w_state_nxt = CRC_HI;
         CRC_HI: if (w_ack) w_state_nxt = EOP;
         EOP:    if (eop_done) w_state_nxt = DONE;
         DONE:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_byte  <= 8'h00;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_pkt   <= 3'b000;
         r_cnt   <= '0;
         r_crc   <= 16'hFFFF;
      end else begin
         r_err <= w_reject;
         case (r_state)
            IDLE: begin
               if (w_launch) begin
                  r_byte  <= 8'h80;
                  r_valid <= 1'b1;
                  r_pkt   <= tx_packet;
                  r_cnt   <= w_in_data ? tx_data_count[CW-1:0] : '0;
                  r_crc   <= 16'hFFFF;
               end
            end
            SYNC: if (w_ack) r_byte <= w_pid;
            PID: begin
               if (w_ack) begin
                  if (!w_pkt_data) begin
                     r_valid <= 1'b0;
                  end else if (w_cnt_zero) begin
                     r_byte <= ~r_crc[7:0];
                  end else begin
                     r_byte <= buf_data;
                     r_crc  <= w_crc_nxt;
                  end
               end
            end
            DATA: begin
               if (w_ack) begin
                  r_cnt <= r_cnt - CW'(1);
                  if (w_cnt_last) begin
                     r_byte <= ~r_crc[7:0];
                  end else begin
                     r_byte <= buf_data;
                     r_crc  <= w_crc_nxt;
                  end
               end
            end
            CRC_LO: if (w_ack) r_byte <= ~r_crc[15:8];
            CRC_HI: if (w_ack) r_valid <= 1'b0;
            DONE:   r_pkt <= 3'b000;
            default: ;
         endcase
      end
   end

   assign buf_get    = w_get;
   assign byte_out   = r_byte;
   assign byte_valid = r_valid;
   assign eop_req    = (r_state == EOP);
   assign tx_busy    = (r_state != IDLE);
   assign tx_done    = (r_state == DONE);
   assign tx_error   = r_err;

endmodule

// File: tb/tb_usb_tx_packet_gen.sv
// Randomized bench for usb_tx_packet_gen: a serializer/FIFO model drives the
// DUT and the captured byte stream is compared with a reference packet builder.
module tb_usb_tx_packet_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_start = 1'b0;
   logic [2:0] tx_packet = 3'b000;
   logic [6:0] tx_data_count = 7'd0;
   logic [7:0] buf_data = 8'h00;
   logic       buf_get;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       byte_ack = 1'b0;
   logic       eop_req;
   logic       eop_done = 1'b0;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] pl[$];
   logic [7:0] exp_q[$];

   usb_tx_packet_gen #(.MAX_BYTES(64)) dut (
      .clk(clk), .rst(rst), .tx_start(tx_start), .tx_packet(tx_packet),
      .tx_data_count(tx_data_count), .buf_data(buf_data), .buf_get(buf_get),
      .byte_out(byte_out), .byte_valid(byte_valid), .byte_ack(byte_ack),
      .eop_req(eop_req), .eop_done(eop_done), .tx_busy(tx_busy),
      .tx_done(tx_done), .tx_error(tx_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pid_of(input logic [2:0] p);
      case (p)
         3'd1: return 8'hC3;
         3'd2: return 8'h4B;
         3'd3: return 8'hD2;
         3'd4: return 8'h5A;
         3'd5: return 8'h1E;
         default: return 8'h00;
      endcase
   endfunction

   // Non-reflected shift over the LSB-first bit stream, reflected at the end.
   function automatic logic [15:0] ref_crc(input logic [7:0] d[$]);
      logic [15:0] c;
      logic [15:0] r;
      logic        fb;
      c = 16'hFFFF;
      foreach (d[k]) begin
         for (int i = 0; i < 8; i++) begin
            fb = c[15] ^ d[k][i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
         end
      end
      for (int i = 0; i < 16; i++) r[i] = c[15-i];
      return ~r;
   endfunction

   function automatic int next_delay(input int bp);
      if (bp >= 0)  return bp;
      if (bp == -1) return int'($urandom_range(0, 3));
      return 0;
   endfunction

   // bp: >=0 fixed ack delay, -1 random delay, -2 byte_ack tied high.
   task automatic run_pkt(input logic [2:0] pt, input int cnt, input int bp,
                          input bit abort, input string nm);
      logic [7:0] got[$];
      logic [15:0] crc;
      logic [7:0] pb = 8'h00;
      logic pv = 1'b0, pa = 1'b0, pg = 1'b0;
      int gets = 0, idx = 0, cyc = 0, wcnt = 0, edl = 0;
      int done_cyc = -1, eopd_cyc = -1, ndone = 0, unstable = 0;
      int dbl_get = 0, overlap = 0, errs = 0, busy_drop = 0;
      bit is_data, fin = 1'b0;
      is_data = (pt == 3'd1) || (pt == 3'd2);
      exp_q = {8'h80, pid_of(pt)};
      if (is_data) begin
         foreach (pl[k]) exp_q.push_back(pl[k]);
         crc = ref_crc(pl);
         exp_q.push_back(crc[7:0]);
         exp_q.push_back(crc[15:8]);
      end
      tx_start = 1'b1; tx_packet = pt; tx_data_count = cnt[6:0];
      byte_ack = 1'b0; eop_done = 1'b0;
      @(negedge clk);
      tx_start = 1'b0;
      #1;
      chk({nm, "_sync_vld"}, byte_valid, 1);
      chk({nm, "_sync_byte"}, byte_out, 8'h80);
      chk({nm, "_sync_busy"}, tx_busy, 1);
      wcnt = next_delay(bp);
      edl  = $urandom_range(0, 3);
      while (!fin && cyc < 3000) begin
         if (abort && gets == 3) begin
            rst = 1'b1; tx_start = 1'b1; tx_packet = 3'b011;
            byte_ack = 1'b1; eop_done = 1'b0;
            #1;
            chk({nm, "_rst_get"}, buf_get, 0);
            chk({nm, "_pre_len"}, got.size(), 4);
            for (int k = 0; k < 4 && k < got.size(); k++)
               chk($sformatf("%s_pre_b%0d", nm, k), got[k], exp_q[k]);
            @(negedge clk); #1;
            chk({nm, "_outs_zero"},
                {byte_out, byte_valid, buf_get, eop_req, tx_busy, tx_done, tx_error}, 0);
            rst = 1'b0; tx_start = 1'b0; byte_ack = 1'b0;
            return;
         end
         tx_start      = ($urandom_range(0, 3) == 0);
         tx_packet     = 3'($urandom);
         tx_data_count = 7'($urandom);
         buf_data      = (idx < pl.size()) ? pl[idx] : 8'($urandom);
         if (bp == -2)      byte_ack = 1'b1;
         else if (bp == -1) byte_ack = byte_valid ? (wcnt == 0) : 1'($urandom);
         else               byte_ack = byte_valid && (wcnt == 0);
         eop_done = eop_req ? (edl == 0) : 1'($urandom);
         #1;
         if (pv && !pa && !(byte_valid && byte_out == pb)) unstable++;
         if (byte_valid && byte_ack) got.push_back(byte_out);
         if (buf_get) begin
            gets++; idx++;
            if (pg) dbl_get++;
         end
         if (eop_req && byte_valid) overlap++;
         if (tx_error) errs++;
         if (!tx_busy) busy_drop++;
         if (eop_req && eop_done && eopd_cyc < 0) eopd_cyc = cyc;
         if (tx_done) begin ndone++; done_cyc = cyc; fin = 1'b1; end
         if (byte_valid) begin
            if (byte_ack) wcnt = next_delay(bp);
            else if (wcnt > 0) wcnt--;
         end
         if (eop_req && edl > 0) edl--;
         pv = byte_valid; pa = byte_ack; pb = byte_out; pg = buf_get;
         cyc++;
         if (!fin) @(negedge clk);
      end
      if (!fin) chk({nm, "_timeout"}, 0, 1);
      chk({nm, "_len"}, got.size(), exp_q.size());
      foreach (exp_q[k])
         chk($sformatf("%s_b%0d", nm, k), (k < got.size()) ? {24'h0, got[k]} : 32'hDEAD, exp_q[k]);
      chk({nm, "_gets"}, gets, is_data ? cnt : 0);
      chk({nm, "_unstable"}, unstable, 0);
      chk({nm, "_overlap"}, overlap, 0);
      chk({nm, "_err"}, errs, 0);
      chk({nm, "_busy"}, busy_drop, 0);
      chk({nm, "_ndone"}, ndone, 1);
      chk({nm, "_done_lat"}, done_cyc, eopd_cyc + 1);
      if (bp >= 0) chk({nm, "_dbl_get"}, dbl_get, 0);
      @(negedge clk);
      tx_start = 1'b0; byte_ack = 1'b0; eop_done = 1'b0;
      #1;
      chk({nm, "_done_end"}, tx_done, 0);
      chk({nm, "_idle_busy"}, tx_busy, 0);
   endtask

   task automatic reject(input logic [2:0] pt, input int cnt, input string nm);
      tx_start = 1'b1; tx_packet = pt; tx_data_count = cnt[6:0];
      @(negedge clk);
      tx_start = 1'b0;
      #1;
      chk({nm, "_err"}, tx_error, 1);
      chk({nm, "_busy"}, tx_busy, 0);
      chk({nm, "_vld"}, byte_valid, 0);
      @(negedge clk); #1;
      chk({nm, "_err_end"}, tx_error, 0);
      chk({nm, "_busy2"}, tx_busy, 0);
      chk({nm, "_vld2"}, byte_valid, 0);
      chk({nm, "_get"}, buf_get, 0);
   endtask

   initial begin
      logic [2:0] pt;
      int cnt;
      rst = 1'b1; tx_start = 1'b1; tx_packet = 3'b011;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_outs", {byte_out, byte_valid, buf_get, eop_req, tx_busy, tx_done, tx_error}, 0);
      tx_start = 1'b0; rst = 1'b0;
      @(negedge clk);

      pl.delete();
      run_pkt(3'b011, 0, -2, 1'b0, "ack");
      pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      run_pkt(3'b001, 9, -1, 1'b0, "d0crc");
      pl.delete();
      run_pkt(3'b010, 0, -1, 1'b0, "d1empty");
      pl.delete();
      repeat (6) pl.push_back(8'($urandom));
      run_pkt(3'b001, 6, 5, 1'b0, "bp");
      reject(3'b111, 0, "rej_ill");
      reject(3'b001, 65, "rej_long");
      reject(3'b000, 3, "rej_zero");
      pl.delete();
      repeat (64) pl.push_back(8'($urandom));
      run_pkt(3'b010, 64, -1, 1'b0, "max");

      for (int n = 0; n < 12; n++) begin
         pt = 3'($urandom_range(1, 5));
         pl.delete();
         if (pt == 3'd1 || pt == 3'd2) begin
            cnt = $urandom_range(0, 20);
            repeat (cnt) pl.push_back(8'($urandom));
         end else begin
            cnt = $urandom_range(0, 127);
         end
         run_pkt(pt, cnt, -1, 1'b0, $sformatf("rnd%0d", n));
      end

      pl.delete();
      repeat (8) pl.push_back(8'($urandom));
      run_pkt(3'b001, 8, -1, 1'b1, "abort");
      pl.delete();
      run_pkt(3'b100, 0, -1, 1'b0, "nak");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
